// File: rtl/axis_frame_source.sv
// axis_frame_source
//   Streams one IMG_WIDTH x IMG_HEIGHT frame from a synchronous single-port
//   pixel memory onto an AXI4-Stream master. TUSER flags the first pixel,
//   TLAST the last. A 2-entry prefetch buffer absorbs TREADY backpressure.
//
// Ports
//   ACLK, ARESETn        clock, async active-low reset
//   start                one-cycle frame request (honoured only when idle)
//   rd_en, rd_addr       pixel memory read strobe / linear raster address
//   rd_data              {R,G,B}, valid one cycle after rd_en
//   M_AXIS_*             AXI4-Stream master, TDATA = {8'd0, R, G, B}
//   busy, done           frame in progress / one-cycle completion pulse
//
// state  | meaning
// S_IDLE | waiting for start, busy low
// S_RUN  | issuing reads 0..N-1 as buffer credit allows
// S_DRAIN| all reads issued, emptying buffer until beat N-1 transfers
// S_DONE | done pulse for one cycle, then back to idle
`timescale 1ns/1ps

module axis_frame_source #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int ADDR_W     = 18
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [31:0]       M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TUSER,
  input  logic              M_AXIS_TREADY,
  output logic              busy,
  output logic              done
);

  localparam int                N        = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_beat;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic [23:0]       r_buf0;
  logic [23:0]       r_buf1;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  logic              w_valid;
  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_issue;
  logic [23:0]       w_head;

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid & M_AXIS_TREADY;
  // Occupancy the buffer will reach once the inflight read lands and this
  // cycle's pop retires; a new read is only allowed while that stays below 2.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (w_level < 3'd2);
  assign w_head  = r_rd_ptr ? r_buf1 : r_buf0;

  assign rd_en         = w_issue;
  assign rd_addr       = r_addr;
  assign M_AXIS_TVALID = w_valid;
  assign M_AXIS_TDATA  = w_valid ? {8'd0, w_head} : 32'd0;
  // Frame tags follow the beat counter, so they stay correct under stalls.
  assign M_AXIS_TUSER  = w_valid && (r_beat == '0);
  assign M_AXIS_TLAST  = w_valid && (r_beat == LAST_IDX);
  assign busy          = r_busy;
  assign done          = r_done;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (r_inflight) begin
        if (r_wr_ptr) r_buf1 <= rd_data;
        else          r_buf0 <= rd_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) r_addr <= r_addr + ADDR_W'(1);
      if (w_pop)   r_beat <= r_beat + ADDR_W'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_issue && (r_addr == LAST_IDX)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && (r_beat == LAST_IDX)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
`timescale 1ns/1ps

module tb_axis_frame_source;

  localparam int AW = 18;
  localparam int WS [3] = '{4, 16, 1};
  localparam int HS [3] = '{2, 16, 1};
  localparam int NS [3] = '{8, 256, 1};

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] data;
    logic        user;
    logic        last;
  } exp_t;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          start_s  [3];
  logic          rd_en_s  [3];
  logic [AW-1:0] rd_addr_s[3];
  logic [23:0]   rd_data_s[3];
  logic [31:0]   tdata_s  [3];
  logic          tvalid_s [3];
  logic          tlast_s  [3];
  logic          tuser_s  [3];
  logic          tready_s [3];
  logic          busy_s   [3];
  logic          done_s   [3];

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  int          m_occ [3];
  logic        m_inf [3];
  int          m_addr[3];
  logic        m_run [3];
  int          beats [3];
  int          rmode [3];
  logic        p_stall[3];
  logic [31:0] p_data[3];
  logic        p_user[3];
  logic        p_last[3];
  int          stall_cnt = 0;

  always #5 ACLK = ~ACLK;

  // Pixel memory contents: a hand-written table for the 4x2 frame, a simple
  // address-derived pattern for the others.
  function automatic logic [23:0] pix(input int inst, input logic [AW-1:0] a);
    logic [23:0] r;
    if (inst == 0) begin
      case (a[2:0])
        3'd0: r = 24'h102030;
        3'd1: r = 24'hA1B2C3;
        3'd2: r = 24'hFF0001;
        3'd3: r = 24'h00FF7E;
        3'd4: r = 24'h123456;
        3'd5: r = 24'h89ABCD;
        3'd6: r = 24'h5A5AA5;
        default: r = 24'hDEAD01;
      endcase
    end else begin
      r = {a[7:0] ^ 8'h3C, a[15:8] + 8'(inst), ~a[7:0]};
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axis_frame_source #(
      .IMG_WIDTH (WS[g]),
      .IMG_HEIGHT(HS[g]),
      .ADDR_W    (AW)
    ) u_dut (
      .ACLK         (ACLK),
      .ARESETn      (ARESETn),
      .start        (start_s[g]),
      .rd_en        (rd_en_s[g]),
      .rd_addr      (rd_addr_s[g]),
      .rd_data      (rd_data_s[g]),
      .M_AXIS_TDATA (tdata_s[g]),
      .M_AXIS_TVALID(tvalid_s[g]),
      .M_AXIS_TLAST (tlast_s[g]),
      .M_AXIS_TUSER (tuser_s[g]),
      .M_AXIS_TREADY(tready_s[g]),
      .busy         (busy_s[g]),
      .done         (done_s[g])
    );

    always @(posedge ACLK) begin
      if (rd_en_s[g]) rd_data_s[g] <= pix(g, rd_addr_s[g]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TREADY driver: 0 = always ready, 1 = 10-cycle stall at beat 2, 2 = random.
  always @(posedge ACLK) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      case (rmode[g])
        1: begin
          if (beats[g] == 2 && stall_cnt < 10) begin
            tready_s[g] = 1'b0;
            stall_cnt++;
          end else begin
            tready_s[g] = 1'b1;
          end
        end
        2:       tready_s[g] = 1'($urandom_range(0, 1));
        default: tready_s[g] = 1'b1;
      endcase
    end
  end

  // Monitor: occupancy/credit model, AXI hold rule, scoreboard pops.
  always @(negedge ACLK) begin : mon
    logic pop;
    int   lvl;
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (!ARESETn) begin
        m_occ[g]   = 0;
        m_inf[g]   = 1'b0;
        p_stall[g] = 1'b0;
      end else begin
        pop = tvalid_s[g] && tready_s[g];
        lvl = m_occ[g] + int'(m_inf[g]) - int'(pop);
        chk("tvalid_vs_occ", 64'(tvalid_s[g]), 64'(m_occ[g] != 0));
        chk("no_overflow", 64'(lvl <= 2), 64'd1);
        chk("rd_en_credit", 64'(rd_en_s[g]), 64'(m_run[g] && (m_addr[g] < NS[g]) && (lvl < 2)));
        if (rd_en_s[g]) begin
          chk("rd_addr", 64'(rd_addr_s[g]), 64'(m_addr[g]));
          m_addr[g]++;
        end
        if (p_stall[g]) begin
          chk("hold_valid", 64'(tvalid_s[g]), 64'd1);
          chk("hold_data", 64'(tdata_s[g]), 64'(p_data[g]));
          chk("hold_user", 64'(tuser_s[g]), 64'(p_user[g]));
          chk("hold_last", 64'(tlast_s[g]), 64'(p_last[g]));
        end
        if (pop) begin
          if (q.size() == 0) begin
            chk("unexpected_beat_inst", 64'(g), 64'hFF);
          end else begin
            e = q.pop_front();
            chk("beat_inst", 64'(g), 64'(e.inst));
            chk("beat_data", 64'(tdata_s[g]), 64'(e.data));
            chk("beat_user", 64'(tuser_s[g]), 64'(e.user));
            chk("beat_last", 64'(tlast_s[g]), 64'(e.last));
          end
          beats[g]++;
        end
        p_stall[g] = tvalid_s[g] && !tready_s[g];
        p_data[g]  = tdata_s[g];
        p_user[g]  = tuser_s[g];
        p_last[g]  = tlast_s[g];
        m_occ[g]   = lvl;
        m_inf[g]   = rd_en_s[g];
      end
    end
  end

  // Call at posedge+1; returns in the first cycle after start was sampled.
  task automatic start_frame(input int g);
    exp_t e;
    start_s[g] = 1'b1;
    @(posedge ACLK);
    #1;
    start_s[g] = 1'b0;
    m_addr[g] = 0;
    m_run[g]  = 1'b1;
    beats[g]  = 0;
    for (int i = 0; i < NS[g]; i++) begin
      e.inst = 2'(g);
      e.data = {8'd0, pix(g, AW'(i))};
      e.user = (i == 0);
      e.last = (i == NS[g] - 1);
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input int g, input int budget, output int k);
    k = 1;
    while (!done_s[g] && k < budget) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    chk("done_seen", 64'(done_s[g]), 64'd1);
  endtask

  task automatic chk_idle(input int g);
    chk("idle_rd_en", 64'(rd_en_s[g]), 64'd0);
    chk("idle_rd_addr", 64'(rd_addr_s[g]), 64'd0);
    chk("idle_tvalid", 64'(tvalid_s[g]), 64'd0);
    chk("idle_tdata", 64'(tdata_s[g]), 64'd0);
    chk("idle_tlast", 64'(tlast_s[g]), 64'd0);
    chk("idle_tuser", 64'(tuser_s[g]), 64'd0);
    chk("idle_busy", 64'(busy_s[g]), 64'd0);
    chk("idle_done", 64'(done_s[g]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_v;
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0; tready_s[g] = 1'b1; rmode[g] = 0;
      m_occ[g] = 0; m_inf[g] = 1'b0; m_addr[g] = 0; m_run[g] = 1'b0;
      beats[g] = 0; p_stall[g] = 1'b0; p_data[g] = '0;
      p_user[g] = 1'b0; p_last[g] = 1'b0;
    end
    repeat (3) @(posedge ACLK);
    #1;
    for (int g = 0; g < 3; g++) chk_idle(g);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // 4x2, TREADY high: exact latency, busy span and done pulse.
    start_frame(0);
    chk("t1_busy_c1", 64'(busy_s[0]), 64'd1);
    chk("t1_rd_en_c1", 64'(rd_en_s[0]), 64'd1);
    chk("t1_tvalid_c1", 64'(tvalid_s[0]), 64'd0);
    k = 1;
    first_v = 0;
    while (!done_s[0] && k < 40) begin
      if (tvalid_s[0] && first_v == 0) first_v = k;
      chk("t1_busy_span", 64'(busy_s[0]), 64'd1);
      @(posedge ACLK);
      #1;
      k++;
    end
    chk("t1_done_seen", 64'(done_s[0]), 64'd1);
    chk("t1_done_cycle", 64'(k), 64'd11);
    chk("t1_busy_at_done", 64'(busy_s[0]), 64'd0);
    chk("t1_first_valid", 64'(first_v), 64'd3);
    @(posedge ACLK);
    #1;
    chk("t1_done_pulse", 64'(done_s[0]), 64'd0);
    chk("t1_busy_after", 64'(busy_s[0]), 64'd0);
    chk("t1_beats", 64'(beats[0]), 64'd8);

    // Same frame with a 10-cycle stall at beat 2.
    rmode[0] = 1;
    stall_cnt = 0;
    start_frame(0);
    wait_done(0, 60, k);
    chk("t2_stall_len", 64'(stall_cnt), 64'd10);
    chk("t2_done_cycle", 64'(k), 64'd21);
    chk("t2_beats", 64'(beats[0]), 64'd8);
    rmode[0] = 0;
    repeat (2) @(posedge ACLK);
    #1;

    // 16x16 with random TREADY.
    rmode[1] = 2;
    start_frame(1);
    wait_done(1, 3000, k);
    chk("t3_beats", 64'(beats[1]), 64'd256);
    rmode[1] = 0;
    repeat (2) @(posedge ACLK);
    #1;

    // 1x1 frame.
    start_frame(2);
    wait_done(2, 20, k);
    chk("t4_done_cycle", 64'(k), 64'd4);
    chk("t4_beats", 64'(beats[2]), 64'd1);
    repeat (2) @(posedge ACLK);
    #1;

    // start mid-frame and in the done cycle is ignored; one cycle later is taken.
    start_frame(0);
    repeat (3) @(posedge ACLK);
    #1;
    start_s[0] = 1'b1;
    @(posedge ACLK);
    #1;
    start_s[0] = 1'b0;
    wait_done(0, 40, k);
    chk("t5_first_beats", 64'(beats[0]), 64'd8);
    start_s[0] = 1'b1;
    @(posedge ACLK);
    #1;
    chk("t5_ignored_at_done", 64'(busy_s[0]), 64'd0);
    start_frame(0);
    chk("t5_second_busy", 64'(busy_s[0]), 64'd1);
    wait_done(0, 40, k);
    chk("t5_second_cycle", 64'(k), 64'd11);
    chk("t5_second_beats", 64'(beats[0]), 64'd8);
    repeat (2) @(posedge ACLK);
    #1;

    // Reset while beat 5 is presented, then a clean frame.
    start_frame(0);
    k = 0;
    while (beats[0] < 5 && k < 40) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    chk("t6_reach_beat5", 64'(beats[0]), 64'd5);
    chk("t6_valid_before_rst", 64'(tvalid_s[0]), 64'd1);
    ARESETn = 1'b0;
    #1;
    chk_idle(0);
    q.delete();
    m_run[0] = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk_idle(0);
    start_frame(0);
    wait_done(0, 40, k);
    chk("t6_done_cycle", 64'(k), 64'd11);
    chk("t6_beats", 64'(beats[0]), 64'd8);
    repeat (2) @(posedge ACLK);
    #1;

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
